mem_fill_responder: RTL and testbench

- Main-memory-side responder for the data cache interface: receives word read/write requests and returns read data after a fixed multi-cycle latency.
- Fully pipelined: a new request is accepted every cycle, so a cache miss handler can stream 8 back-to-back word reads for a block fill.
- Sits between the cache miss/fill controller and the backing storage array; owns the storage array itself.

---
 rtl/mem_fill_if.sv | 15 +
 rtl/mem_fill_responder.sv | 68 ++++++
 tb/tb_mem_fill_responder.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mem_fill_if.sv
// mem_fill_if: request/response bundle between the cache fill controller and mem_fill_responder
interface mem_fill_if #(
    parameter int ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] addr;
    logic [15:0]           data_in;
    logic                  wen;
    logic                  ren;
    logic [15:0]           data_out;
    logic                  data_valid;
    logic [ADDR_WIDTH-1:0] data_addr;
    logic                  busy;
    modport master (output addr, data_in, wen, ren, input data_out, data_valid, data_addr, busy);
    modport slave (input addr, data_in, wen, ren, output data_out, data_valid, data_addr, busy);
endinterface

// File: rtl/mem_fill_responder.sv
// mem_fill_responder: pipelined word memory with fixed read latency; MEM_RAW_FORWARD_EN selects read-at-return forwarding
module mem_fill_responder #(
    parameter int ADDR_WIDTH = 16,
    parameter int MEM_WORDS  = 1024,
    parameter int LATENCY    = 4
) (
    input logic        clk,
    input logic        rst,
    mem_fill_if.slave  bus
);
    localparam int IW = $clog2(MEM_WORDS);
    localparam int CW = $clog2(LATENCY + 1);
    logic [15:0]           mem [MEM_WORDS];
    logic [LATENCY-1:0]    vld_q, vld_d;
    logic [15:0]           dat_q [LATENCY];
    logic [15:0]           dat_d [LATENCY];
    logic [ADDR_WIDTH-1:0] adr_q [LATENCY];
    logic [ADDR_WIDTH-1:0] adr_d [LATENCY];
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  wr, rd;
    logic [IW-1:0]         widx;
    // A simultaneous write wins; the read half of the request is dropped.
    assign wr   = bus.wen;
    assign rd   = bus.ren & ~bus.wen;
    assign widx = bus.addr[IW:1];
    // Storage array is never reset; writes land at the accepting edge.
    always_ff @(posedge clk) begin
        if (wr) mem[widx] <= bus.data_in;
    end
    // Shift pipeline: stage 0 captures the array word, later stages only move when the previous stage is valid, so the last stage holds its value between returns.
    always_comb begin
        vld_d = '0;
        dat_d = dat_q;
        adr_d = adr_q;
        vld_d[0] = rd;
        dat_d[0] = rd ? mem[widx] : dat_q[0];
        adr_d[0] = rd ? {bus.addr[ADDR_WIDTH-1:1], 1'b0} : adr_q[0];
        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            adr_d[i] = vld_q[i-1] ? adr_q[i-1] : adr_q[i];
`ifdef MEM_RAW_FORWARD_EN
            dat_d[i] = !vld_q[i-1] ? dat_q[i] :
                       (wr && adr_q[i-1][IW:1] == widx) ? bus.data_in : dat_q[i-1];
`else
            dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
`endif
        end
        cnt_d = cnt_q + CW'(rd) - CW'(vld_q[LATENCY-1]);
    end
    // Pipeline and in-flight counter registers; reset discards every in-flight read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            dat_q <= '{default: '0};
            adr_q <= '{default: '0};
            cnt_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
            adr_q <= adr_d;
            cnt_q <= cnt_d;
        end
    end
    assign bus.data_out   = dat_q[LATENCY-1];
    assign bus.data_valid = vld_q[LATENCY-1];
    assign bus.data_addr  = adr_q[LATENCY-1];
    assign bus.busy       = |vld_q;
endmodule

// File: tb/tb_mem_fill_responder.sv
// tb_mem_fill_responder: directed checks of latency, ordering, reset flush and aliasing for mem_fill_responder
module tb_mem_fill_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    mem_fill_if #(.ADDR_WIDTH(16)) bus ();
    mem_fill_responder #(.ADDR_WIDTH(16), .MEM_WORDS(1024), .LATENCY(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic wr_word(input logic [15:0] a, input logic [15:0] d);
        bus.addr = a;
        bus.data_in = d;
        bus.wen = 1'b1;
        bus.ren = 1'b0;
        step();
        bus.wen = 1'b0;
    endtask
    task automatic rd_chk(input string tag, input logic [15:0] a, input logic [15:0] exp);
        bus.addr = a;
        bus.ren = 1'b1;
        bus.wen = 1'b0;
        step();
        bus.ren = 1'b0;
        chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
        step();
        step();
        chk({tag, "_early"}, 32'(bus.data_valid), 32'd0);
        step();
        chk({tag, "_dv"}, 32'(bus.data_valid), 32'd1);
        chk({tag, "_data"}, 32'(bus.data_out), 32'(exp));
        chk({tag, "_addr"}, 32'(bus.data_addr), 32'({a[15:1], 1'b0}));
        step();
        chk({tag, "_pulse"}, 32'(bus.data_valid), 32'd0);
    endtask
    initial begin
        int pulses;
        int lo;
        int hi;
        bus.addr = '0;
        bus.data_in = '0;
        bus.wen = 1'b0;
        bus.ren = 1'b0;
        step();
        step();
        chk("rst_dv", 32'(bus.data_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_data", 32'(bus.data_out), 32'd0);
        chk("rst_addr", 32'(bus.data_addr), 32'd0);
        chk("rst_cnt", 32'(dut.cnt_q), 32'd0);
        rst = 1'b0;
        step();
        bus.addr = 16'h0010;
        bus.ren = 1'b1;
        step();
        bus.addr = 16'h0012;
        step();
        bus.ren = 1'b0;
        chk("flight_cnt", 32'(dut.cnt_q), 32'd2);
        step();
        step();
        rst = 1'b1;
        #1;
        chk("flush_busy", 32'(bus.busy), 32'd0);
        chk("flush_cnt", 32'(dut.cnt_q), 32'd0);
        step();
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.data_valid) pulses++;
        end
        chk("flush_pulses", 32'(pulses), 32'd0);
        wr_word(16'h0040, 16'hBEEF);
        rd_chk("single", 16'h0040, 16'hBEEF);
        for (int i = 0; i < 8; i++) wr_word(16'(16'h1000 + 2 * i), 16'(16'hA000 + i));
        for (int c = 0; c < 12; c++) begin
            bus.ren = (c < 8);
            bus.addr = 16'(16'h1000 + 2 * c);
            step();
            lo = (c - 3 > 0) ? c - 3 : 0;
            hi = (c < 7) ? c : 7;
            chk("burst_cnt", 32'(dut.cnt_q), 32'((hi >= lo) ? hi - lo + 1 : 0));
            chk("burst_busy", 32'(bus.busy), 32'(c <= 10));
            chk("burst_dv", 32'(bus.data_valid), 32'(c >= 3 && c <= 10));
            if (c >= 3 && c <= 10) begin
                chk("burst_data", 32'(bus.data_out), 32'(16'hA000 + c - 3));
                chk("burst_addr", 32'(bus.data_addr), 32'(16'h1000 + 2 * (c - 3)));
            end
        end
        bus.ren = 1'b0;
        bus.addr = 16'h0020;
        bus.data_in = 16'h1234;
        bus.wen = 1'b1;
        bus.ren = 1'b1;
        step();
        bus.wen = 1'b0;
        bus.ren = 1'b0;
        chk("wr_rd_busy", 32'(bus.busy), 32'd0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.data_valid) pulses++;
        end
        chk("wr_rd_pulses", 32'(pulses), 32'd0);
        rd_chk("wr_rd_read", 16'h0020, 16'h1234);
        wr_word(16'h0050, 16'h1111);
        bus.addr = 16'h0050;
        bus.ren = 1'b1;
        step();
        bus.ren = 1'b0;
        wr_word(16'h0050, 16'h2222);
        step();
        step();
        chk("hazard_dv", 32'(bus.data_valid), 32'd1);
`ifdef MEM_RAW_FORWARD_EN
        chk("hazard_data", 32'(bus.data_out), 32'h2222);
`else
        chk("hazard_data", 32'(bus.data_out), 32'h1111);
`endif
        step();
        wr_word(16'h0060, 16'h7777);
        bus.addr = 16'h0060;
        bus.ren = 1'b1;
        step();
        bus.ren = 1'b0;
        step();
        step();
        step();
        chk("ret_wr_dv", 32'(bus.data_valid), 32'd1);
        chk("ret_wr_data", 32'(bus.data_out), 32'h7777);
        wr_word(16'h0060, 16'h8888);
        rd_chk("ret_wr_after", 16'h0060, 16'h8888);
        wr_word(16'h0801, 16'h5555);
        rd_chk("alias", 16'h0000, 16'h5555);
        rd_chk("odd", 16'h0041, 16'hBEEF);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
